// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with rotate, parallel load and shift counter
//
// Purpose: WIDTH-bit register that can hold, shift right, shift left or parallel
// load. Shifts take serial input or rotate. A saturating counter tracks the
// number of shifts since the last load or reset.
//
// Ports:
//   CLK   - clock; all state changes on its rising edge
//   CLEAR - asynchronous active-high reset (Q <= RESET_VAL, CNT <= 0)
//   EN    - active-high clock enable
//   MODE  - 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   ROT   - 1: shifts rotate; 0: shifts take SIR/SIL
//   SIR   - serial bit entering the MSB on a right shift
//   SIL   - serial bit entering the LSB on a left shift
//   D     - parallel load data
//   Q     - register contents
//   SOR   - Q[0]
//   SOL   - Q[WIDTH-1]
//   CNT   - shifts since last load/reset, saturating at WIDTH
//   DONE  - CNT == WIDTH
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             CLEAR,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             ROT,
  input  logic             SIR,
  input  logic             SIL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic [CW-1:0]    CNT,
  output logic             DONE
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic right_in;
  logic left_in;

  // Bit shifted in: the bit falling off the opposite end when rotating.
  assign right_in = ROT ? Q[0]       : SIR;
  assign left_in  = ROT ? Q[WIDTH-1] : SIL;

  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      Q   <= RESET_VAL;
      CNT <= '0;
    end else if (EN) begin
      case (MODE)
        MODE_RIGHT: begin
          Q <= {right_in, Q[WIDTH-1:1]};
          if (CNT != CNT_MAX) CNT <= CNT + CW'(1);
        end
        MODE_LEFT: begin
          Q <= {Q[WIDTH-2:0], left_in};
          if (CNT != CNT_MAX) CNT <= CNT + CW'(1);
        end
        MODE_LOAD: begin
          Q   <= D;
          CNT <= '0;
        end
        MODE_HOLD: begin
          Q   <= Q;
          CNT <= CNT;
        end
        default: begin
          Q   <= Q;
          CNT <= CNT;
        end
      endcase
    end
  end

  assign SOR  = Q[0];
  assign SOL  = Q[WIDTH-1];
  assign DONE = (CNT == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       rot;
    logic       sir;
    logic       sil;
    logic [7:0] d;
    logic [7:0] eq;
    logic [3:0] ec;
  } vec_t;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        rot = 1'b0;
  logic        sir = 1'b0;
  logic        sil = 1'b0;
  logic [7:0]  d = 8'h00;
  logic [15:0] d16 = 16'h0000;

  logic [7:0]  q;
  logic        sor, sol, done;
  logic [3:0]  cnt;
  logic [15:0] q16;
  logic        sor16, sol16, done16;
  logic [4:0]  cnt16;

  int n_cmp = 0;
  int n_fail = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8)) dut (
    .CLK(clk), .CLEAR(clear), .EN(en), .MODE(mode), .ROT(rot), .SIR(sir), .SIL(sil),
    .D(d), .Q(q), .SOR(sor), .SOL(sol), .CNT(cnt), .DONE(done)
  );

  univ_shift_reg #(.WIDTH(16), .RESET_VAL(16'hBEEF)) dut16 (
    .CLK(clk), .CLEAR(clear), .EN(en), .MODE(mode), .ROT(rot), .SIR(sir), .SIL(sil),
    .D(d16), .Q(q16), .SOR(sor16), .SOL(sol16), .CNT(cnt16), .DONE(done16)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic [1:0] m, input logic r,
                              input logic si_r, input logic si_l, input logic [7:0] dd,
                              input logic [7:0] eq, input logic [3:0] ec);
    vec_t v;
    v.en = e; v.mode = m; v.rot = r; v.sir = si_r; v.sil = si_l; v.d = dd;
    v.eq = eq; v.ec = ec;
    return v;
  endfunction

  task automatic chk8(input string nm, input logic [7:0] eq, input logic [3:0] ec);
    chk({nm, ".q"}, q, eq);
    chk({nm, ".cnt"}, cnt, ec);
    chk({nm, ".done"}, done, (ec == 4'd8));
    chk({nm, ".sor"}, sor, eq[0]);
    chk({nm, ".sol"}, sol, eq[7]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mq, mc, b;
    logic [7:0] fq;

    // Asynchronous reset before any clock edge
    #1 clear = 1'b1;
    #1;
    chk8("reset_async", 8'h00, 4'd0);
    chk("reset16.q", q16, 16'hBEEF);
    tick();
    clear = 1'b0;

    // Directed table: loads, shifts, rotates, saturation, enable gating
    vecs.push_back(mk(1, 2'b11, 0, 0, 0, 8'hB4, 8'hB4, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h5A, 1));
    vecs.push_back(mk(1, 2'b10, 0, 0, 1, 8'h00, 8'hB5, 2));
    vecs.push_back(mk(1, 2'b11, 1, 1, 1, 8'h81, 8'h81, 0));
    vecs.push_back(mk(1, 2'b10, 1, 0, 0, 8'h00, 8'h03, 1));
    vecs.push_back(mk(1, 2'b11, 0, 0, 0, 8'h81, 8'h81, 0));
    vecs.push_back(mk(1, 2'b01, 1, 0, 0, 8'h00, 8'hC0, 1));
    vecs.push_back(mk(1, 2'b11, 0, 0, 0, 8'hFF, 8'hFF, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h7F, 1));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h3F, 2));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h1F, 3));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h0F, 4));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h07, 5));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h03, 6));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h01, 7));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h00, 8));
    vecs.push_back(mk(1, 2'b01, 0, 1, 0, 8'h00, 8'h80, 8));
    vecs.push_back(mk(1, 2'b10, 0, 0, 1, 8'h00, 8'h01, 8));
    vecs.push_back(mk(1, 2'b11, 0, 0, 0, 8'h12, 8'h12, 0));
    vecs.push_back(mk(1, 2'b11, 0, 0, 0, 8'h78, 8'h78, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h3C, 1));
    vecs.push_back(mk(0, 2'b01, 0, 1, 1, 8'hFF, 8'h3C, 1));
    vecs.push_back(mk(0, 2'b10, 1, 1, 1, 8'hFF, 8'h3C, 1));
    vecs.push_back(mk(0, 2'b11, 0, 1, 1, 8'hFF, 8'h3C, 1));
    vecs.push_back(mk(1, 2'b00, 1, 1, 1, 8'hFF, 8'h3C, 1));
    vecs.push_back(mk(1, 2'b11, 0, 0, 0, 8'h14, 8'h14, 0));
    vecs.push_back(mk(1, 2'b10, 0, 0, 1, 8'h00, 8'h29, 1));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 8'h00, 8'h52, 2));
    vecs.push_back(mk(1, 2'b10, 0, 0, 1, 8'h00, 8'hA5, 3));

    foreach (vecs[i]) begin
      en = vecs[i].en; mode = vecs[i].mode; rot = vecs[i].rot;
      sir = vecs[i].sir; sil = vecs[i].sil; d = vecs[i].d;
      tick();
      chk8($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ec);
    end

    // Clear between edges from Q=A5/CNT=3, held across shift edges
    en = 1'b1; mode = 2'b01; rot = 1'b0; sir = 1'b1;
    #2 clear = 1'b1;
    #1;
    chk8("clear_mid", 8'h00, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk8($sformatf("clear_hold%0d", i), 8'h00, 4'd0);
    end
    mode = 2'b11; d = 8'h5C;
    clear = 1'b0;
    tick();
    chk8("after_clear_load", 8'h5C, 4'd0);

    // Width 16 with non-zero reset value
    #1 clear = 1'b1;
    #1;
    chk("w16_reset.q", q16, 16'hBEEF);
    chk("w16_reset.sor", sor16, 1'b1);
    chk("w16_reset.sol", sol16, 1'b1);
    chk("w16_reset.done", done16, 1'b0);
    clear = 1'b0;
    mode = 2'b10; rot = 1'b0; sil = 1'b0; en = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("w16_15.cnt", cnt16, 5'd15);
    chk("w16_15.done", done16, 1'b0);
    chk("w16_15.q", q16, 16'h8000);
    tick();
    chk("w16_16.q", q16, 16'h0000);
    chk("w16_16.cnt", cnt16, 5'd16);
    chk("w16_16.done", done16, 1'b1);

    // Randomized run against an arithmetic reference model
    mode = 2'b11; d = 8'h00;
    tick();
    mq = 0; mc = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        clear = 1'b1;
        #1;
        mq = 0; mc = 0;
        fq = 8'(mq);
        chk8($sformatf("rnd_clr%0d", i), fq, 4'(mc));
        clear = 1'b0;
      end
      en   = ($urandom_range(0, 7) != 0);
      mode = 2'($urandom_range(0, 3));
      if (mode == 2'b11 && $urandom_range(0, 3) != 0) mode = 2'($urandom_range(0, 2));
      rot  = 1'($urandom_range(0, 1));
      sir  = 1'($urandom_range(0, 1));
      sil  = 1'($urandom_range(0, 1));
      d    = 8'($urandom_range(0, 255));
      tick();
      if (en) begin
        if (mode == 2'b01) begin
          b  = rot ? (mq % 2) : int'(sir);
          mq = mq / 2 + b * 128;
          mc = (mc < 8) ? mc + 1 : 8;
        end else if (mode == 2'b10) begin
          b  = rot ? (mq / 128) : int'(sil);
          mq = (mq * 2) % 256 + b;
          mc = (mc < 8) ? mc + 1 : 8;
        end else if (mode == 2'b11) begin
          mq = int'(d);
          mc = 0;
        end
      end
      fq = 8'(mq);
      chk8($sformatf("rnd%0d", i), fq, 4'(mc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH shall default to 8 and set register width; legal range 2..64.
REQ-002 Parameter RESET_VAL shall default to 0 (WIDTH bits) and set the value Q takes on reset.
REQ-003 Port CLK shall be an input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port CLEAR shall be an input, 1 bit: asynchronous, active-high reset.
REQ-005 Port EN shall be an input, 1 bit: clock enable, active-high.
REQ-006 Port MODE shall be an input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port ROT shall be an input, 1 bit: when 1, shifts rotate instead of taking serial input.
REQ-008 Port SIR shall be an input, 1 bit: serial data entering the MSB on a right shift.
REQ-009 Port SIL shall be an input, 1 bit: serial data entering the LSB on a left shift.
REQ-010 Port D shall be an input, WIDTH bits: parallel load data.
REQ-011 Port Q shall be an output, WIDTH bits: register contents.
REQ-012 Port SOR shall be an output, 1 bit: equal to Q[0].
REQ-013 Port SOL shall be an output, 1 bit: equal to Q[WIDTH-1].
REQ-014 Port CNT shall be an output, clog2(WIDTH+1) bits: number of shifts since the last load or reset.
REQ-015 Port DONE shall be an output, 1 bit: high when CNT equals WIDTH.

Function
REQ-016 Q, CNT and the internal state shall update only on a rising CLK edge with CLEAR=0 and EN=1.
REQ-017 With EN=0, Q and CNT shall hold, regardless of MODE, ROT, SIR, SIL or D.
REQ-018 MODE=00 shall hold Q and CNT.
REQ-019 MODE=01, ROT=0 shall set Q to {SIR, Q[WIDTH-1:1]}.
REQ-020 MODE=01, ROT=1 shall set Q to {Q[0], Q[WIDTH-1:1]}; SIR is ignored.
REQ-021 MODE=10, ROT=0 shall set Q to {Q[WIDTH-2:0], SIL}.
REQ-022 MODE=10, ROT=1 shall set Q to {Q[WIDTH-2:0], Q[WIDTH-1]}; SIL is ignored.
REQ-023 MODE=11 shall set Q to D and CNT to 0, ignoring ROT, SIR and SIL.
REQ-024 Each enabled shift (MODE 01 or 10) shall increment CNT by 1, saturating at WIDTH with no wrap to 0.
REQ-025 Shifts shall continue to move Q after CNT saturates; only CNT is frozen.
REQ-026 DONE shall be combinational from CNT: 1 iff CNT==WIDTH.
REQ-027 SOR and SOL shall be combinational from Q with no added latency.
REQ-028 Latency from a qualifying edge to the new Q, CNT and DONE shall be one edge, visible immediately after that edge.
REQ-029 A direction change between consecutive edges (01 then 10) shall need no idle cycle; CNT shall count both shifts.

Reset
REQ-030 While CLEAR=1, Q shall be RESET_VAL, CNT 0 and DONE 0, asynchronously, without waiting for CLK.
REQ-031 CLEAR asserted mid-operation shall override any load or shift in the same cycle.
REQ-032 On the first rising CLK edge after CLEAR falls, the block shall act normally per EN and MODE.
REQ-033 SOR and SOL shall reflect RESET_VAL bits 0 and WIDTH-1 during reset.

Verification (WIDTH=8 unless noted)
REQ-034 Q=8'hA5, CNT=3; raise CLEAR between edges -> Q=8'h00, CNT=0, DONE=0 before the next edge; hold for 3 edges with MODE=01 -> Q stays 8'h00.
REQ-035 Load 8'hB4; 1 edge MODE=01, ROT=0, SIR=0 -> Q=8'h5A, SOR=0, CNT=1; 1 edge MODE=10, SIL=1 -> Q=8'hB5, CNT=2.
REQ-036 Load 8'h81; 1 edge MODE=10, ROT=1 -> Q=8'h03; reload 8'h81; 1 edge MODE=01, ROT=1 -> Q=8'hC0.
REQ-037 Load 8'hFF; 8 edges MODE=01, SIR=0 -> Q=8'h00, CNT=8, DONE=1 after the 8th edge; 9th shift -> CNT=8, DONE=1; load 8'h12 -> CNT=0, DONE=0, Q=8'h12.
REQ-038 Q=8'h3C; EN=0 with MODE=01, 10, then 11 (D=8'hFF), one edge each -> Q=8'h3C and CNT unchanged throughout.
REQ-039 WIDTH=16, RESET_VAL=16'hBEEF; pulse CLEAR -> Q=16'hBEEF, SOR=1, SOL=1; 16 left shifts with SIL=0 -> Q=16'h0000, DONE=1.
